ram_write_driver: RTL

Loads neural-network weights into the 1024x8 weight block RAM, the write-side counterpart of the RAM read driver. Accepts a byte stream over a valid/ready handshake and writes it sequentially into the 256-byte region of the selected layer. Asserts a one-cycle completion pulse so the network controller can start the read-out pass. Shares the RAM address/data port conventions of the read path; the RAM's write port is driven exclusively by this block.

---
 rtl/ram_write_driver_pkg.sv | 29 ++
 rtl/ram_write_driver.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/ram_write_driver_pkg.sv
// Shared constants, state encoding and address helpers for the weight RAM
// read/write drivers.
package ram_write_driver_pkg;

  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 8;
  localparam int LAYER_SIZE = 256;
  localparam int LAYER_W    = 2;
  localparam int LEN_W      = 9;
  localparam int OFS_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // First RAM address of a layer region.
  function automatic logic [ADDR_W-1:0] layer_base(input logic [LAYER_W-1:0] layer);
    return ADDR_W'(layer) * ADDR_W'(LAYER_SIZE);
  endfunction

  // A request is legal when it fits in one layer region and is not empty.
  function automatic logic length_ok(input logic [LEN_W-1:0] len);
    return (len != 9'd0) && (len <= 9'd256);
  endfunction

endpackage

// File: rtl/ram_write_driver.sv
// Streams weight bytes into one 256-byte layer region of the weight RAM.
// Optional WRITE_DRIVER_CHECKSUM_EN adds a trailing mod-256 checksum byte.
module ram_write_driver
  import ram_write_driver_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LAYER_W-1:0] layer,
  input  logic [LEN_W-1:0]  length,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] RAM_address,
  output logic [DATA_W-1:0] RAM_din,
  output logic              RAM_we,
  output logic              busy,
  output logic              load_done,
  output logic              error
);

  state_t               state_r;
  state_t               state_s;
  logic [LAYER_W-1:0]   layer_r;
  logic [LEN_W-1:0]     len_r;
  logic [LEN_W-1:0]     count_r;
  logic                 handshake_s;
  logic                 last_s;
`ifdef WRITE_DRIVER_CHECKSUM_EN
  logic [DATA_W-1:0]    sum_r;
`endif

  assign handshake_s = in_valid & in_ready;
  assign last_s      = (state_r == ST_LOAD) && handshake_s && (count_r == len_r - 9'd1);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && length_ok(length)) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (last_s) begin
`ifdef WRITE_DRIVER_CHECKSUM_EN
          state_s = ST_CHECK;
`else
          state_s = ST_DONE;
`endif
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_CHECK: begin
`ifdef WRITE_DRIVER_CHECKSUM_EN
        if (handshake_s) begin
          state_s = (in_data == sum_r) ? ST_DONE : ST_IDLE;
        end else begin
          state_s = ST_CHECK;
        end
`else
        state_s = ST_IDLE;
`endif
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state only.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state_r)
      ST_IDLE:  begin in_ready = 1'b0; busy = 1'b0; end
      ST_LOAD:  begin in_ready = 1'b1; busy = 1'b1; end
      ST_CHECK: begin in_ready = 1'b1; busy = 1'b1; end
      ST_DONE:  begin in_ready = 1'b0; busy = 1'b1; end
      default:  begin in_ready = 1'b0; busy = 1'b0; end
    endcase
  end

  // Request latch, offset counter, registered RAM write and status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      layer_r     <= '0;
      len_r       <= '0;
      count_r     <= '0;
      RAM_address <= '0;
      RAM_din     <= '0;
      RAM_we      <= 1'b0;
      load_done   <= 1'b0;
      error       <= 1'b0;
`ifdef WRITE_DRIVER_CHECKSUM_EN
      sum_r       <= '0;
`endif
    end else begin
      RAM_we    <= 1'b0;
      error     <= 1'b0;
      load_done <= (state_s == ST_DONE);
      if ((state_r == ST_IDLE) && start) begin
        if (length_ok(length)) begin
          layer_r <= layer;
          len_r   <= length;
          count_r <= '0;
`ifdef WRITE_DRIVER_CHECKSUM_EN
          sum_r   <= '0;
`endif
        end else begin
          error <= 1'b1;
        end
      end
      if ((state_r == ST_LOAD) && handshake_s) begin
        RAM_we      <= 1'b1;
        RAM_address <= layer_base(layer_r) + ADDR_W'(count_r[OFS_W-1:0]);
        RAM_din     <= in_data;
        count_r     <= count_r + 9'd1;
`ifdef WRITE_DRIVER_CHECKSUM_EN
        sum_r       <= sum_r + in_data;
`endif
      end
`ifdef WRITE_DRIVER_CHECKSUM_EN
      if ((state_r == ST_CHECK) && handshake_s && (in_data != sum_r)) begin
        error <= 1'b1;
      end
`endif
    end
  end

endmodule
